// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port memory bus between the instruction fetch (IF) stage
// and the memory access (MEM) stage of the pipeline. When both stages request
// at the same time, the stage that was not granted last wins (round-robin).
// Each transfer is a strobe/ack handshake on the bus. The winning stage gets
// the read data together with a one-cycle ack pulse. A transfer that never
// receives a bus ack is aborted after TIMEOUT busy cycles and flagged on err_o.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   if_*              fetch port: read request, address, read data, ack pulse
//   mem_*             load/store port: request, we, address, byte enables,
//                     write data, read data, ack pulse
//   bus_*             shared bus: registered strobe, we, address, byte enables,
//                     write data; read data and ack from the memory
//   stallreq_o        high while any stage has a request that is not yet acked
//   err_o, err_src_o  timeout abort pulse and the stage it hit (0=IF, 1=MEM)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              stallreq_o,
    output logic              err_o,
    output logic              err_src_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Last busy-cycle count before an abort; only meaningful when TIMEOUT != 0.
    localparam logic [7:0] TO_LAST   = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         TO_ENABLE = (TIMEOUT != 0);

    state_t     state;
    logic       last_mem;   // 1 when the previous grant went to MEM
    logic       owner_mem;  // 1 when the transfer in flight belongs to MEM
    logic [7:0] cnt;
    logic       grant_mem;

    // MEM wins when it is the only requester, or when both request and IF
    // was served last. Only looked at in IDLE.
    assign grant_mem = mem_req_i & (~if_req_i | ~last_mem);

    // A stage stalls the pipeline from its request until its ack pulse.
    assign stallreq_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

    // Single FSM: IDLE arbitrates and loads the bus fields, BUSY waits for the
    // bus ack or the timeout, RESP holds the one-cycle ack/err pulse. RESP does
    // no arbitration, so the still-high request of the stage just acked cannot
    // win a second grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_mem    <= 1'b0;
            owner_mem   <= 1'b0;
            cnt         <= 8'd0;
            if_data_o   <= '0;
            if_ack_o    <= 1'b0;
            mem_rdata_o <= '0;
            mem_ack_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= 4'h0;
            bus_wdata_o <= '0;
            err_o       <= 1'b0;
            err_src_o   <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req_i || mem_req_i) begin
                        if (grant_mem) begin
                            bus_we_o    <= mem_we_i;
                            bus_addr_o  <= mem_addr_i;
                            bus_sel_o   <= mem_sel_i;
                            bus_wdata_o <= mem_wdata_i;
                        end else begin
                            bus_we_o    <= 1'b0;
                            bus_addr_o  <= if_addr_i;
                            bus_sel_o   <= 4'hF;
                            bus_wdata_o <= '0;
                        end
                        owner_mem <= grant_mem;
                        last_mem  <= grant_mem;
                        bus_stb_o <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // A real ack always beats a timeout on the same edge.
                    if (bus_ack_i) begin
                        bus_stb_o <= 1'b0;
                        if (owner_mem) begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= bus_rdata_i;
                        end else begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= bus_rdata_i;
                        end
                        state <= RESP;
                    end else if (TO_ENABLE && (cnt == TO_LAST)) begin
                        // Abort: the stage still gets its ack so it can move
                        // on, with zero data and an error pulse.
                        bus_stb_o <= 1'b0;
                        if (owner_mem) begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= '0;
                        end else begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= '0;
                        end
                        err_o     <= 1'b1;
                        err_src_o <= owner_mem;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter, built with TIMEOUT=4. Stimulus is
// a linear sequence of directed and randomized transfers. The reference model
// only tracks who was served last, the data each port should hold and the
// last error source; expected bus behaviour per transfer comes from the
// arbitration and handshake rules (winner, ack latency, timeout after
// TIMEOUT unacknowledged busy cycles).
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stallreq_o;
    logic        err_o;
    logic        err_src_o;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          last_mem;
    logic [31:0] exp_if_data;
    logic [31:0] exp_mem_data;
    bit          exp_err_src;

    mem_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_data_o  (if_data_o),
        .if_ack_o   (if_ack_o),
        .mem_req_i  (mem_req),
        .mem_we_i   (mem_we),
        .mem_addr_i (mem_addr),
        .mem_sel_i  (mem_sel),
        .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata_o),
        .mem_ack_o  (mem_ack_o),
        .bus_stb_o  (bus_stb_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_sel_o  (bus_sel_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata),
        .bus_ack_i  (bus_ack),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .err_src_o  (err_src_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are sampled and
    // inputs driven here, well away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_mem     = 1'b0;
        exp_if_data  = '0;
        exp_mem_data = '0;
        exp_err_src  = 1'b0;
    endtask

    // Runs one complete transfer starting in an IDLE cycle with requests
    // already driven. The bus acks on busy cycle 'delay' (0 = first cycle);
    // a delay of TB_TIMEOUT or more never acks and must time out.
    task automatic do_transfer(input int delay, input logic [31:0] rdata);
        bit          win_mem;
        bit          done;
        bit          exp_err;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        bit          e_we;

        win_mem = mem_req && (!if_req || !last_mem);
        e_addr  = win_mem ? mem_addr : if_addr;
        e_sel   = win_mem ? mem_sel : 4'hF;
        e_we    = win_mem ? mem_we : 1'b0;
        exp_err = 1'b0;

        step();
        check_output("grant_stb", bus_stb_o, 1);
        check_output("grant_addr", bus_addr_o, e_addr);
        check_output("grant_sel", bus_sel_o, e_sel);
        check_output("grant_we", bus_we_o, e_we);
        if (win_mem) check_output("grant_wdata", bus_wdata_o, mem_wdata);
        check_output("grant_stall", stallreq_o, 1);
        last_mem = win_mem;

        done = 1'b0;
        for (int e = 0; e < TB_TIMEOUT && !done; e++) begin
            bus_ack   = (e == delay);
            bus_rdata = rdata;
            step();
            if (e == delay) begin
                done = 1'b1;
                if (win_mem) exp_mem_data = rdata;
                else         exp_if_data  = rdata;
            end else if (e == TB_TIMEOUT - 1) begin
                done        = 1'b1;
                exp_err     = 1'b1;
                exp_err_src = win_mem;
                if (win_mem) exp_mem_data = '0;
                else         exp_if_data  = '0;
            end else begin
                check_output("busy_stb", bus_stb_o, 1);
                check_output("busy_addr", bus_addr_o, e_addr);
                check_output("busy_sel", bus_sel_o, e_sel);
                check_output("busy_ack", {30'd0, if_ack_o, mem_ack_o}, 0);
            end
        end
        bus_ack = 1'b0;

        check_output("resp_stb", bus_stb_o, 0);
        check_output("resp_if_ack", if_ack_o, !win_mem);
        check_output("resp_mem_ack", mem_ack_o, win_mem);
        check_output("resp_if_data", if_data_o, exp_if_data);
        check_output("resp_mem_data", mem_rdata_o, exp_mem_data);
        check_output("resp_err", err_o, exp_err);
        check_output("resp_err_src", err_src_o, exp_err_src);
        check_output("resp_stall", stallreq_o, win_mem ? if_req : mem_req);

        step();
        check_output("idle_ack", {30'd0, if_ack_o, mem_ack_o}, 0);
        check_output("idle_err", err_o, 0);
        check_output("idle_if_data", if_data_o, exp_if_data);
        check_output("idle_mem_data", mem_rdata_o, exp_mem_data);
        check_output("idle_err_src", err_src_o, exp_err_src);
        if (win_mem) mem_req = 1'b0;
        else         if_req  = 1'b0;
        #1;
        check_output("idle_stall", stallreq_o, if_req | mem_req);
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_sel   = 4'h0;
        mem_wdata = '0;
        bus_rdata = '0;
        bus_ack   = 1'b0;
        model_reset();

        // Reset state.
        step();
        step();
        check_output("rst_stb", bus_stb_o, 0);
        check_output("rst_ack", {30'd0, if_ack_o, mem_ack_o}, 0);
        check_output("rst_err", {30'd0, err_o, err_src_o}, 0);
        check_output("rst_if_data", if_data_o, 0);
        check_output("rst_mem_data", mem_rdata_o, 0);
        check_output("rst_stall", stallreq_o, 0);
        rst = 1'b1;

        // Both request at the first IDLE: MEM first, then strict alternation.
        for (int r = 0; r < 2; r++) begin
            if_addr   = 32'h0000_1000 + 32'(r * 4);
            mem_addr  = 32'h0000_2000 + 32'(r * 4);
            mem_we    = 1'b0;
            mem_sel   = 4'hF;
            mem_wdata = 32'h0;
            if_req    = 1'b1;
            mem_req   = 1'b1;
            #1;
            check_output("both_stall", stallreq_o, 1);
            do_transfer(0, $urandom);
            do_transfer(1, $urandom);
        end

        // Fetch with the fastest bus response.
        if_addr = 32'h0000_0100;
        if_req  = 1'b1;
        do_transfer(0, 32'h3C01_0001);

        // Store acked on the last busy cycle before the timeout would hit.
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0040;
        mem_sel   = 4'b0011;
        mem_wdata = 32'hDEAD_BEEF;
        mem_req   = 1'b1;
        do_transfer(TB_TIMEOUT - 1, $urandom);

        // Fetch never acked: abort with error; then a fetch acked at the limit.
        if_addr = 32'h0000_0200;
        if_req  = 1'b1;
        do_transfer(TB_TIMEOUT + 3, $urandom);
        if_req = 1'b1;
        do_transfer(TB_TIMEOUT - 1, $urandom);

        // A bus ack while IDLE with no request is ignored.
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        step();
        step();
        check_output("stray_ack", {30'd0, if_ack_o, mem_ack_o}, 0);
        check_output("stray_stb", bus_stb_o, 0);
        check_output("stray_if_data", if_data_o, exp_if_data);
        bus_ack = 1'b0;

        // Randomized mix of requesters, fields and bus latencies.
        for (int r = 0; r < 24; r++) begin
            int pick;
            pick      = int'($urandom_range(1, 3));
            if_addr   = $urandom;
            mem_addr  = $urandom ^ 32'h8000_0000;
            mem_we    = 1'($urandom_range(0, 1));
            mem_sel   = 4'($urandom);
            mem_wdata = $urandom;
            if (if_addr == mem_addr) mem_addr = ~if_addr;
            if_req    = pick[0];
            mem_req   = pick[1];
            #1;
            check_output("rand_stall", stallreq_o, 1);
            do_transfer(int'($urandom_range(0, 5)), $urandom);
            if (pick == 3) do_transfer(int'($urandom_range(0, 5)), $urandom);
        end

        // Reset in the middle of a fetch while a load is waiting.
        if_addr   = 32'h0000_0300;
        if_req    = 1'b1;
        step();
        check_output("pre_rst_stb", bus_stb_o, 1);
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_0500;
        mem_sel   = 4'hF;
        mem_req   = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_output("midrst_stb", bus_stb_o, 0);
        check_output("midrst_addr", bus_addr_o, 0);
        check_output("midrst_ack", {30'd0, if_ack_o, mem_ack_o}, 0);
        check_output("midrst_err", {30'd0, err_o, err_src_o}, 0);
        check_output("midrst_if_data", if_data_o, 0);
        check_output("midrst_mem_data", mem_rdata_o, 0);
        model_reset();
        if_req = 1'b0;
        step();
        step();
        check_output("midrst_hold_stb", bus_stb_o, 0);
        rst = 1'b1;
        do_transfer(1, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
